// File: rtl/store_buffer_if.sv
// store_buffer_if: handshake and bus bundle between MEM/control/dcache and the store buffer.
// Signals:
//   put_enable/put_addr/put_data/put_size  committed store from MEM
//   get_enable                              drain request for the head entry
//   dcache_wr_ready                         dcache accepts the presented write
//   dcache_wr_valid/addr/data/be            head entry presented to dcache
//   snoop_addr/snoop_size                   load probe from MEM
//   full/empty                              occupancy flags
//   snoop_hit/snoop_line_conflict/snoop_data snoop results for control
// Modports: master drives stores, drains and snoops; slave is the store buffer.
interface store_buffer_if;
    logic        put_enable;
    logic [31:0] put_addr;
    logic [31:0] put_data;
    logic [1:0]  put_size;
    logic        get_enable;
    logic        dcache_wr_ready;
    logic        dcache_wr_valid;
    logic [31:0] dcache_wr_addr;
    logic [31:0] dcache_wr_data;
    logic [3:0]  dcache_wr_be;
    logic [31:0] snoop_addr;
    logic [1:0]  snoop_size;
    logic        full;
    logic        empty;
    logic        snoop_hit;
    logic        snoop_line_conflict;
    logic [31:0] snoop_data;

    modport master (
        output put_enable, put_addr, put_data, put_size, get_enable, dcache_wr_ready,
        output snoop_addr, snoop_size,
        input  dcache_wr_valid, dcache_wr_addr, dcache_wr_data, dcache_wr_be,
        input  full, empty, snoop_hit, snoop_line_conflict, snoop_data
    );

    modport slave (
        input  put_enable, put_addr, put_data, put_size, get_enable, dcache_wr_ready,
        input  snoop_addr, snoop_size,
        output dcache_wr_valid, dcache_wr_addr, dcache_wr_data, dcache_wr_be,
        output full, empty, snoop_hit, snoop_line_conflict, snoop_data
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: post-commit FIFO of stores between MEM and the dcache write port, with load snoop.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset; discards all pending entries
//   sb       store_buffer_if.slave: store put, head drain to dcache, load snoop, full/empty
// Parameters: DEPTH (entries, power of two >= 2), LINE_BYTES (dcache line, power of two >= 4).
// Option: define STORE_BUFFER_SNOOP_FWD_EN to enable store-to-load forwarding; when undefined,
//   snoop_hit/snoop_data stay 0 and any same-line entry raises snoop_line_conflict.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int LINE_BYTES = 16
) (
    input logic           clk,
    input logic           reset_n,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(LINE_BYTES);

    function automatic logic [3:0] lane_be(input logic [1:0] a, input logic [1:0] s);
        return s == 2'd0 ? 4'b0001 << a : s == 2'd1 ? 4'b0011 << {a[1], 1'b0} : 4'hF;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] s);
        return s == 2'd0 ? {4{d[7:0]}} : s == 2'd1 ? {2{d[15:0]}} : d;
    endfunction

    logic [DEPTH-1:0] vld;
    logic [29:0]      wa_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic             do_put;
    logic             do_pop;
    logic             line_any;
    logic             hit;

    assign sb.full            = count == (PW+1)'(DEPTH);
    assign sb.empty           = count == '0;
    assign sb.dcache_wr_valid = sb.get_enable && !sb.empty;
    assign sb.dcache_wr_addr  = {wa_q[head], 2'b00};
    assign sb.dcache_wr_data  = data_q[head];
    assign sb.dcache_wr_be    = be_q[head];

    // full is the pre-edge flag, so a put while full is dropped even if the head pops.
    assign do_put = sb.put_enable && !sb.full;
    assign do_pop = sb.dcache_wr_valid && sb.dcache_wr_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_put) vld[tail] <= 1'b1;
            if (do_pop) vld[head] <= 1'b0;
            tail  <= tail + PW'(do_put);
            head  <= head + PW'(do_pop);
            count <= count + (PW+1)'(do_put) - (PW+1)'(do_pop);
        end
    end

    // Payload needs no reset: it is only observed through the valid bits and count.
    always_ff @(posedge clk) begin
        if (do_put) begin
            wa_q[tail]   <= sb.put_addr[31:2];
            data_q[tail] <= lane_data(sb.put_data, sb.put_size);
            be_q[tail]   <= lane_be(sb.put_addr[1:0], sb.put_size);
        end
    end

    // Line membership does not depend on age, so every slot is checked directly.
    always_comb begin
        line_any = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && wa_q[i][29:LW-2] == sb.snoop_addr[31:LW]) line_any = 1'b1;
    end

`ifdef STORE_BUFFER_SNOOP_FWD_EN
    logic [3:0]    load_be;
    logic [PW-1:0] pos;
    logic [PW-1:0] sel;
    logic          match;

    // Walk oldest to youngest; the last word match left in sel is the youngest.
    always_comb begin
        load_be = lane_be(sb.snoop_addr[1:0], sb.snoop_size);
        match   = 1'b0;
        pos     = head;
        sel     = head;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head + PW'(i);
            if (vld[pos] && wa_q[pos] == sb.snoop_addr[31:2]) begin
                match = 1'b1;
                sel   = pos;
            end
        end
        hit = match && ((be_q[sel] & load_be) == load_be);
    end

    assign sb.snoop_data = hit ? data_q[sel] : '0;
`else
    logic unused_snoop_bits;

    assign unused_snoop_bits = ^{sb.snoop_size, sb.snoop_addr[1:0]};
    assign hit               = 1'b0;
    assign sb.snoop_data     = '0;
`endif

    assign sb.snoop_hit           = hit;
    assign sb.snoop_line_conflict = line_any && !hit;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer; expected drains are queued at put time.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [29:0] wa;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    ent_t model[$];

    store_buffer_if sb_if();

    store_buffer #(.DEPTH(DEPTH), .LINE_BYTES(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sb(sb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mk_be(input logic [1:0] a, input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0001 << a;
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] mk_data(input logic [31:0] d, input logic [1:0] s);
        case (s)
            2'd0:    return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd1:    return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic idle_inputs();
        sb_if.put_enable      = 1'b0;
        sb_if.put_addr        = '0;
        sb_if.put_data        = '0;
        sb_if.put_size        = '0;
        sb_if.get_enable      = 1'b0;
        sb_if.dcache_wr_ready = 1'b0;
    endtask

    // One clock: drive, check the presented head and flags, then update the model at the edge.
    task automatic cycle(input logic pe, input logic [31:0] pa, input logic [31:0] pd,
                         input logic [1:0] ps, input logic ge, input logic rdy);
        bit   do_put;
        bit   do_pop;
        ent_t e;
        sb_if.put_enable      = pe;
        sb_if.put_addr        = pa;
        sb_if.put_data        = pd;
        sb_if.put_size        = ps;
        sb_if.get_enable      = ge;
        sb_if.dcache_wr_ready = rdy;
        #1;
        check("empty", sb_if.empty, model.size() == 0);
        check("full", sb_if.full, model.size() == DEPTH);
        check("wr_valid", sb_if.dcache_wr_valid, ge && model.size() > 0);
        if (ge && model.size() > 0) begin
            check("wr_addr", sb_if.dcache_wr_addr, {model[0].wa, 2'b00});
            check("wr_data", sb_if.dcache_wr_data, model[0].data);
            check("wr_be", sb_if.dcache_wr_be, model[0].be);
        end
        do_pop = ge && rdy && model.size() > 0;
        do_put = pe && model.size() < DEPTH;
        @(posedge clk);
        if (do_pop) void'(model.pop_front());
        if (do_put) begin
            e.wa   = pa[31:2];
            e.data = mk_data(pd, ps);
            e.be   = mk_be(pa[1:0], ps);
            model.push_back(e);
        end
        #1;
        idle_inputs();
    endtask

    task automatic snoop(input string tag, input logic [31:0] a, input logic [1:0] s);
        logic [3:0]  lbe;
        logic        found;
        logic        line_any;
        logic        hit;
        logic [31:0] d;
        ent_t        sel;
        lbe      = mk_be(a[1:0], s);
        found    = 1'b0;
        line_any = 1'b0;
        sel      = '0;
        sb_if.snoop_addr = a;
        sb_if.snoop_size = s;
        #1;
        foreach (model[i]) begin
            if (model[i].wa == a[31:2]) begin
                found = 1'b1;
                sel   = model[i];
            end
            if (model[i].wa[29:2] == a[31:4]) line_any = 1'b1;
        end
`ifdef STORE_BUFFER_SNOOP_FWD_EN
        hit = found && ((sel.be & lbe) == lbe);
`else
        hit = 1'b0;
`endif
        d = hit ? sel.data : 32'h0;
        check({tag, ".hit"}, sb_if.snoop_hit, hit);
        check({tag, ".conflict"}, sb_if.snoop_line_conflict, line_any && !hit);
        check({tag, ".data"}, sb_if.snoop_data, d);
    endtask

    task automatic drain_all();
        while (model.size() > 0) cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        sb_if.snoop_addr = 32'h1000;
        sb_if.snoop_size = 2'd2;
        sb_if.get_enable = 1'b1;
        #2;
        check("rst_empty", sb_if.empty, 1'b1);
        check("rst_full", sb_if.full, 1'b0);
        check("rst_valid", sb_if.dcache_wr_valid, 1'b0);
        check("rst_hit", sb_if.snoop_hit, 1'b0);
        check("rst_conflict", sb_if.snoop_line_conflict, 1'b0);
        check("rst_sdata", sb_if.snoop_data, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // single word through the buffer
        cycle(1'b1, 32'h1000, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
        check("t1_head_data", sb_if.dcache_wr_data, 32'hDEADBEEF);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 0, 0, 1'b0, 1'b0);

        // fill, overflow put dropped, full put+pop, ordered drain with pointer wrap
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h100 + 32'(i * 4), 32'h01010101 * (i + 1), 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h500, 32'hBAD0BAD0, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h600, 32'hBAD1BAD1, 2'd2, 1'b1, 1'b1);
        drain_all();

        // partial vs full coverage of a byte store
        cycle(1'b1, 32'h2003, 32'h000000AB, 2'd0, 1'b0, 1'b0);
        snoop("w2000", 32'h2000, 2'd2);
        snoop("b2003", 32'h2003, 2'd0);
        snoop("h2002", 32'h2002, 2'd1);
        snoop("w2008", 32'h2008, 2'd2);
        snoop("w2010", 32'h2010, 2'd2);
`ifdef STORE_BUFFER_SNOOP_FWD_EN
        check("fwd_byte", sb_if.snoop_data, 32'h0);
`endif
        drain_all();

        // youngest same-word entry wins; half with addr[0] ignored
        cycle(1'b1, 32'h3000, 32'h11111111, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h3000, 32'h22222222, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h3007, 32'h0000CAFE, 2'd1, 1'b0, 1'b0);
        snoop("w3000", 32'h3000, 2'd2);
        snoop("h3006", 32'h3006, 2'd1);
        snoop("b3004", 32'h3004, 2'd0);
        drain_all();

        // stalled drain, then put+pop at count 2
        cycle(1'b1, 32'h4000, 32'hA0A0A0A0, 2'd2, 1'b0, 1'b0);
        cycle(1'b1, 32'h4004, 32'hB1B1B1B1, 2'd2, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cycle(1'b1, 32'h4008, 32'hC2C2C2C2, 2'd2, 1'b1, 1'b1);
        drain_all();

        // asynchronous reset with entries pending
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h5000 + 32'(i * 4), 32'h5A5A0000 + 32'(i), 2'd2, 1'b0, 1'b0);
        sb_if.get_enable = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_empty", sb_if.empty, 1'b1);
        check("arst_full", sb_if.full, 1'b0);
        check("arst_valid", sb_if.dcache_wr_valid, 1'b0);
        model.delete();
        #1;
        reset_n = 1'b1;
        sb_if.get_enable = 1'b0;
        cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
        snoop("post_rst", 32'h5000, 2'd2);
        cycle(1'b1, 32'h6000, 32'h600DF00D, 2'd2, 1'b0, 1'b0);
        drain_all();

        // random mix of puts, stalled/accepted drains and snoops over a small address window
        for (int n = 0; n < 120; n++) begin
            cycle(1'($urandom_range(0, 1)), 32'h7000 + 32'($urandom_range(0, 31)), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            snoop("rnd", 32'h7000 + 32'($urandom_range(0, 39)), 2'($urandom_range(0, 3)));
        end
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the MEM stage and the data cache write port. Accepts committed stores from MEM (`mem_sb_put_enable`), holds them in FIFO order, and drains the oldest entry to the dcache when control asserts `mem_sb_get_enable`. Loads snoop the buffer in the same cycle: full-coverage hits forward data, and same-line partial matches raise a line conflict so control stalls and drains. It produces the `store_buffer_full/empty/snoop_hit/snoop_line_conflict` signals consumed by `control`.

## Interface
- `DEPTH`, 4: number of entries, power of two, ≥2.
- `LINE_BYTES`, 16: dcache line size in bytes, power of two, ≥4. Line index is `addr[31:$clog2(LINE_BYTES)]`.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `put_enable_i` in 1: enqueue a store this cycle.
- `put_addr_i` in 32: store byte address.
- `put_data_i` in 32: store data, right-justified (byte in [7:0], half in [15:0]).
- `put_size_i` in 2: 0 byte, 1 half, 2 word (3 treated as word).
- `get_enable_i` in 1: control requests a drain of the head entry.
- `dcache_wr_ready_i` in 1: dcache accepts the presented write this cycle.
- `dcache_wr_valid_o` out 1: head write presented.
- `dcache_wr_addr_o` out 32: head word address, low 2 bits zero.
- `dcache_wr_data_o` out 32: head data, lane-aligned.
- `dcache_wr_be_o` out 4: head byte enables.
- `snoop_addr_i` in 32: load byte address from MEM.
- `snoop_size_i` in 2: load size, same encoding.
- `full_o` out 1, `empty_o` out 1: occupancy flags.
- `snoop_hit_o` out 1: youngest same-word entry covers every loaded byte.
- `snoop_line_conflict_o` out 1: some entry is in the load's line and `snoop_hit_o` is 0.
- `snoop_data_o` out 32: lane-aligned word from the hitting entry; 0 when no hit.

## Operation
- Storage is a circular FIFO with head/tail pointers of `$clog2(DEPTH)` bits and a count of `$clog2(DEPTH)+1` bits. Each entry holds valid, `addr[31:2]`, data[31:0] and be[3:0].
- Enqueue, when `put_enable_i && !full_o`:
  - byte: be = `4'b0001 << addr[1:0]`, data = `{4{put_data_i[7:0]}}`.
  - half: be = `4'b0011 << {addr[1],1'b0}`, data = `{2{put_data_i[15:0]}}`; `addr[0]` is ignored.
  - word: be = `4'hF`, data = `put_data_i`.
- A put while full is dropped silently. Control guarantees this never occurs.
- Drain: `dcache_wr_valid_o = get_enable_i && !empty_o`, and the `dcache_wr_*` outputs always show the head entry. The head pops when `dcache_wr_valid_o && dcache_wr_ready_i`.
- Put and pop in the same cycle are both performed; the count is unchanged. This holds when full too (the pop happens, and the put is still dropped because `full_o` is sampled pre-edge).
- Snoop is combinational over the registered entries only. A same-cycle put is not visible to the snoop.
  - The load byte mask is built with the same rules as enqueue.
  - The youngest valid entry with an equal word address is selected.
  - The result is a hit if `(entry.be & load_be) == load_be`.
- `snoop_line_conflict_o` = any valid entry with an equal line index AND `!snoop_hit_o`. This covers partial-word overlap as well as a different word in the same line.
- The snoop runs whether or not a load is valid. Control qualifies it.

## Timing
- Reset, async on `reset_n_i` low: all valid bits 0, pointers 0, count 0.
  - Output values during reset: `empty_o`=1, `full_o`=0, `dcache_wr_valid_o`=0, snoop outputs 0.
  - Entries pending at reset are discarded.
- Enqueue latency is 1 cycle: an entry is visible to the snoop and drain the cycle after the put.
- `full_o` = (count==DEPTH) and `empty_o` = (count==0). Both are registered-state derived, with no combinational path from put/get.
- Pointers wrap from DEPTH-1 to 0.
- Drain is one entry per cycle at most. Back-to-back pops are allowed while ready stays high.

## Configuration
- `STORE_BUFFER_SNOOP_FWD_EN`
  - Defined: forwarding behaves as described above.
  - Undefined: `snoop_hit_o` and `snoop_data_o` are tied to 0, so any same-line entry, including an exact word match, asserts `snoop_line_conflict_o` and forces a drain before the load proceeds.

## Test plan
- Reset, then put word 0x1000=0xDEADBEEF -> next cycle `empty_o`=0. With get+ready asserted, the outputs show addr 0x1000, data 0xDEADBEEF, be 0xF, and `empty_o`=1 the following cycle.
- Four puts with DEPTH=4 -> `full_o`=1; a fifth put is dropped; the drain order matches the put order.
- Put byte 0x2003=0xAB, then snoop word at 0x2000 -> hit=0 and conflict=1. Snoop byte at 0x2003 -> hit=1 and `snoop_data_o`=0xABABABAB.
- Put word 0x3000=0x11111111, then word 0x3000=0x22222222. A word snoop at 0x3000 returns 0x22222222, because the youngest entry wins.
- Hold get with ready=0 -> the head stays presented and the count is unchanged. A simultaneous put+pop when count=2 leaves the count at 2.
- Assert reset with 3 entries queued -> `empty_o`=1 immediately and `dcache_wr_valid_o`=0. With the macro undefined, the hit case from scenario 3 reports conflict=1 and hit=0.
